// File: rtl/xof_rej_sampler.sv
// xof_rej_sampler: Kyber uniform rejection sampler on SHAKE128 squeeze blocks.
// Emits 256 coefficients in [0, KYBER_Q). It requests a new 168-byte block
// each time the current one runs out before the polynomial is complete.
// Optional build macro REJ_SAMPLER_STATS_EN adds a saturating reject counter
// output (oRejects).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// REQ      | one-cycle block_req pulse to the squeeze producer
// WAIT_BLK | block buffer empty, iBlock_ready high
// PARSE_D1 | first candidate of the current 3-byte group
// PARSE_D2 | second candidate of the group, then advance the byte pointer
// DONE     | one-cycle done pulse after coefficient 255
module xof_rej_sampler #(
  parameter int KYBER_N     = 256,
  parameter int KYBER_Q     = 3329,
  parameter int Block_Bytes = 168,
  parameter int Block_Size  = Block_Bytes * 8,
  parameter int Coeff_Width = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [Block_Size-1:0]  iBlock,
  input  logic                   iBlock_valid,
  output logic                   iBlock_ready,
  output logic                   block_req,
  output logic [Coeff_Width-1:0] oCoeff,
  output logic [7:0]             oIndex,
  output logic                   oCoeff_valid,
  input  logic                   oCoeff_ready,
`ifdef REJ_SAMPLER_STATS_EN
  output logic [9:0]             oRejects,
`endif
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_BLK, PARSE_D1, PARSE_D2, DONE
  } state_t;

  state_t                state;
  logic [Block_Size-1:0] blk;
  logic [7:0]            ptr;
  logic [7:0]            count;
  logic [10:0]           grp_lsb;
  logic [23:0]           grp;
  logic [11:0]           d1, d2;
  logic                  d1_ok, d2_ok;
  logic                  last_grp;
  logic                  last_coeff;

  // Byte 0 sits in the MSBs, so group ptr occupies bits down from 8*ptr
  // below the top. grp_lsb stays in range because ptr never passes 165.
  assign grp_lsb    = 11'(Block_Size - 24) - {ptr, 3'b000};
  assign grp        = blk[grp_lsb +: 24];
  assign d1         = {grp[11:8], grp[23:16]};
  assign d2         = {grp[7:0], grp[15:12]};
  assign d1_ok      = d1 < 12'(KYBER_Q);
  assign d2_ok      = d2 < 12'(KYBER_Q);
  assign last_grp   = (ptr + 8'd3) == 8'(Block_Bytes);
  assign last_coeff = count == 8'(KYBER_N - 1);

  // Outputs are pure decodes of registered state so they hold steady under backpressure.
  always_comb begin
    busy         = state != IDLE;
    block_req    = state == REQ;
    iBlock_ready = state == WAIT_BLK;
    done         = state == DONE;
    oIndex       = count;
    oCoeff_valid = ((state == PARSE_D1) && d1_ok) || ((state == PARSE_D2) && d2_ok);
    oCoeff       = '0;
    if (oCoeff_valid) oCoeff = (state == PARSE_D2) ? d2 : d1;
  end

  // Sequencer: block fetch, candidate walk and coefficient handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      blk   <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count <= '0;
          ptr   <= '0;
          state <= REQ;
        end
        REQ: state <= WAIT_BLK;
        WAIT_BLK: if (iBlock_valid) begin
          blk   <= iBlock;
          ptr   <= '0;
          state <= PARSE_D1;
        end
        PARSE_D1: begin
          if (!d1_ok) state <= PARSE_D2;
          else if (oCoeff_ready) begin
            count <= count + 8'd1;
            state <= last_coeff ? DONE : PARSE_D2;
          end
        end
        PARSE_D2: begin
          if (d2_ok && oCoeff_ready) count <= count + 8'd1;
          if (d2_ok && oCoeff_ready && last_coeff) state <= DONE;
          else if (!d2_ok || oCoeff_ready) begin
            // A spent block restarts at byte 0 of the next one; no leftovers are kept.
            ptr   <= last_grp ? 8'd0 : ptr + 8'd3;
            state <= last_grp ? REQ : PARSE_D1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REJ_SAMPLER_STATS_EN
  logic rej_now;
  assign rej_now = ((state == PARSE_D1) && !d1_ok) || ((state == PARSE_D2) && !d2_ok);

  // Saturating count of rejected candidates, held after done until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) oRejects <= '0;
    else if ((state == IDLE) && start) oRejects <= '0;
    else if (rej_now && (oRejects != 10'd1023)) oRejects <= oRejects + 10'd1;
  end
`endif

endmodule

// File: tb/tb_xof_rej_sampler.sv
// tb_xof_rej_sampler: directed sequence of polynomials with random and
// crafted squeeze blocks, checked against a byte-stream parse model.
module tb_xof_rej_sampler;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1343:0] iBlock = '0;
  logic          iBlock_valid = 1'b0;
  logic          iBlock_ready, block_req;
  logic [11:0]   oCoeff;
  logic [7:0]    oIndex;
  logic          oCoeff_valid;
  logic          oCoeff_ready = 1'b0;
  logic          busy, done;
`ifdef REJ_SAMPLER_STATS_EN
  logic [9:0]    oRejects;
`endif

  xof_rej_sampler dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .iBlock(iBlock), .iBlock_valid(iBlock_valid), .iBlock_ready(iBlock_ready),
    .block_req(block_req), .oCoeff(oCoeff), .oIndex(oIndex),
    .oCoeff_valid(oCoeff_valid), .oCoeff_ready(oCoeff_ready),
`ifdef REJ_SAMPLER_STATS_EN
    .oRejects(oRejects),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes [8][168];
  int exp_coeff [256];
  int exp_nblk, exp_rej;
  int got, nreq, nblk_taken;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1343:0] pack(input int b);
    logic [1343:0] v;
    v = '0;
    for (int k = 0; k < 168; k++) v[1343 - 8*k -: 8] = bytes[b][k];
    return v;
  endfunction

  // Walk the concatenated byte stream, three bytes per two candidates,
  // stopping at 256 accepted values; each started block costs one request.
  function automatic void model();
    int n, b0, b1, b2, d1, d2;
    n = 0; exp_nblk = 0; exp_rej = 0;
    for (int b = 0; b < 8 && n < 256; b++) begin
      exp_nblk++;
      for (int g = 0; g < 56 && n < 256; g++) begin
        b0 = bytes[b][3*g]; b1 = bytes[b][3*g+1]; b2 = bytes[b][3*g+2];
        d1 = b0 + 256 * (b1 % 16);
        d2 = (b1 / 16) + 16 * b2;
        if (d1 < 3329) begin exp_coeff[n] = d1; n++; end else exp_rej++;
        if (n < 256) begin
          if (d2 < 3329) begin exp_coeff[n] = d2; n++; end else exp_rej++;
        end
      end
    end
  endfunction

  task automatic fill_random();
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 168; k++) bytes[b][k] = 8'($urandom);
  endtask

  task automatic fill_const(input int b, input logic [7:0] v);
    for (int k = 0; k < 168; k++) bytes[b][k] = v;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_iblock_ready"}, iBlock_ready, 0);
    check({tag, "_block_req"}, block_req, 0);
    check({tag, "_coeff"}, oCoeff, 0);
    check({tag, "_index"}, oIndex, 0);
    check({tag, "_coeff_valid"}, oCoeff_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef REJ_SAMPLER_STATS_EN
    check({tag, "_rejects"}, oRejects, 0);
`endif
  endtask

  // One polynomial: start, serve blocks on demand, check every coefficient.
  // stall_idx holds ready low for 5 cycles on that index; abort_at >= 0
  // leaves the run once that many coefficients have been accepted.
  task automatic run_poly(input int stall_idx, input int abort_at, input bit disturb);
    int last_hs, stall, cyc;
    logic [11:0] held_c;
    bit fin, aborted;
    last_hs = -10; stall = 0; fin = 0; aborted = 0; held_c = '0;
    got = 0; nreq = 0; nblk_taken = 0;
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("block_req_after_start", block_req, 1);
    check("busy_after_start", busy, 1);
    nreq = 1;
    @(negedge clk);
    check("iblock_ready_after_start", iBlock_ready, 1);
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (block_req) nreq++;
      if (done) begin
        check("done_latency", cyc - last_hs, 1);
        check("coeff_total", got, 256);
        fin = 1;
      end
      start = 1'b0;
      oCoeff_ready = 1'b0;
      if (abort_at >= 0 && got >= abort_at) begin
        aborted = 1;
        break;
      end
      if (iBlock_ready) begin
        iBlock = pack(nblk_taken % 8);
        iBlock_valid = 1'b1;
        nblk_taken++;
      end else if (disturb && (cyc % 37 == 5)) begin
        iBlock = '1;
        iBlock_valid = 1'b1;
      end else begin
        iBlock_valid = 1'b0;
      end
      if (disturb && oCoeff_valid && (cyc % 41 == 3)) start = 1'b1;
      if (oCoeff_valid) begin
        if (got >= 256) begin
          check("extra_coeff", oIndex, -1);
        end else if (int'(oIndex) == stall_idx && stall < 5) begin
          if (stall > 0) begin
            check("stall_hold_coeff", oCoeff, held_c);
            check("stall_hold_index", oIndex, stall_idx);
          end
          held_c = oCoeff;
          stall++;
        end else begin
          check("coeff", oCoeff, exp_coeff[got]);
          check("index", oIndex, got);
          oCoeff_ready = 1'b1;
          got++;
          last_hs = cyc;
        end
      end else if (!fin) begin
        oCoeff_ready = 1'($urandom);
      end
      @(negedge clk);
    end
    iBlock_valid = 1'b0;
    oCoeff_ready = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      check("finished_in_budget", fin, 1);
      check("block_requests", nreq, exp_nblk);
      check("blocks_taken", nblk_taken, exp_nblk);
      check("idle_after_done_busy", busy, 0);
      check("idle_after_done_pulse", done, 0);
      if (stall_idx >= 0) check("stall_cycles", stall, 5);
`ifdef REJ_SAMPLER_STATS_EN
      check("rejects", oRejects, (exp_rej > 1023) ? 1023 : exp_rej);
`endif
    end
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // all-zero blocks: 112 + 112 + 32 zeros
    for (int b = 0; b < 8; b++) fill_const(b, 8'h00);
    run_poly(-1, -1, 0);
    check("zero_blocks_req", nreq, 3);

    // first block all 0xFF: 112 rejects, then zeros
    fill_const(0, 8'hFF);
    for (int b = 1; b < 8; b++) fill_const(b, 8'h00);
    run_poly(-1, -1, 0);
    check("ff_then_zero_req", nreq, 4);
    check("ff_model_rejects", exp_rej, 112);
`ifdef REJ_SAMPLER_STATS_EN
    check("ff_rejects_const", oRejects, 112);
`endif

    // boundary groups at the start of the first block
    fill_random();
    bytes[0][0] = 8'h00; bytes[0][1] = 8'h0D; bytes[0][2] = 8'hD0;
    bytes[0][3] = 8'h01; bytes[0][4] = 8'h1D; bytes[0][5] = 8'hD0;
    run_poly(-1, -1, 0);
    check("boundary_d1_3328", exp_coeff[0], 3328);
    check("boundary_d2_3328", exp_coeff[1], 3328);

    // random blocks, stall on index 7, stray start and block pulses
    fill_random();
    run_poly(7, -1, 1);

    // reset in the middle of block 2, then a fresh polynomial
    fill_random();
    run_poly(-1, 130, 1);
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    check_reset_values("mid_reset_held");
    reset_n = 1'b1;
    fill_random();
    run_poly(-1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
